// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_pkg
// Purpose  : Shared BIST definitions: session state encoding and the
//            feedback polynomials used by the signature analyzers.
// Revision : 1.0 - initial release
// ============================================================================
package bist_pkg;

  // Session state of a signature analyzer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misrState_t;

  // x^16 + x^12 + x^3 + x + 1, primitive, giving a 65535-step period
  localparam logic [15:0] POLY16_DEFAULT = 16'h100B;

  // x^4 + x + 1, matches the legacy 4-bit MISR so old goldens stay valid
  localparam logic [3:0]  POLY4_LEGACY   = 4'h3;

endpackage
`default_nettype wire

// File: rtl/misr_lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : misr_lfsr_core
// Purpose  : Galois-form multiple-input signature register. Load has
//            priority over enable; the next value is also exported so the
//            caller can compare it in the same cycle it is captured.
// Revision : 1.0 - initial release
// ============================================================================
module misr_lfsr_core #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(16'h100B)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             enable,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sigNext
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  // One compaction step, every bit in parallel from the current value
  for (genvar i = 0; i < WIDTH; i++) begin : g_step
    if (i == 0) begin : g_lsb
      assign w_next[i] = (POLY[i] & r_sig[WIDTH-1]) ^ dataIn[i];
    end else begin : g_upper
      assign w_next[i] = r_sig[i-1] ^ (POLY[i] & r_sig[WIDTH-1]) ^ dataIn[i];
    end
  end

  // Signature register: seed load wins over a compaction step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= loadValue;
    end else if (enable) begin
      r_sig <= w_next;
    end
  end

  assign sig     = r_sig;
  assign sigNext = w_next;

endmodule
`default_nettype wire

// File: rtl/misr_sig_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : misr_sig_analyzer
// Purpose  : MISR with session control. Compacts num_patterns response
//            vectors from a seed, then compares against golden and holds
//            done/pass until the next start.
// Revision : 1.0 - initial release
// ============================================================================
module misr_sig_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(POLY16_DEFAULT),
  parameter int               COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   seed,
  input  logic [COUNT_W-1:0] num_patterns,
  input  logic               data_valid,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH-1:0]   golden,
  output logic [WIDTH-1:0]   sig_out,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  misrState_t         r_state;
  misrState_t         w_stateNext;
  logic [COUNT_W-1:0] r_count;
  logic               r_pass;
  logic [WIDTH-1:0]   w_sigNext;
  logic               w_step;
  logic               w_lastVec;
  logic               w_zeroCount;

  // start in any state restarts; it pre-empts a same-cycle data vector
  assign w_step      = (r_state == RUN) && data_valid && !start;
  assign w_lastVec   = w_step && (r_count == COUNT_W'(1));
  assign w_zeroCount = (num_patterns == '0);

  misr_lfsr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (start),
    .loadValue (seed),
    .enable    (w_step),
    .dataIn    (data_in),
    .sig       (sig_out),
    .sigNext   (w_sigNext)
  );

  // Session state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode: start always opens a new session
  always_comb begin
    w_stateNext = r_state;
    if (start) begin
      w_stateNext = w_zeroCount ? DONE : RUN;
    end else begin
      case (r_state)
        RUN:     if (w_lastVec) w_stateNext = DONE;
        DONE:    w_stateNext = DONE;
        default: w_stateNext = r_state;
      endcase
    end
  end

  // Remaining-vector counter; only decremented on an accepted vector in RUN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= num_patterns;
    end else if (w_step && (r_count != '0)) begin
      r_count <= r_count - COUNT_W'(1);
    end
  end

  // Verdict: golden is looked at only in the cycle the session completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pass <= 1'b0;
    end else if (start) begin
      r_pass <= w_zeroCount && (seed == golden);
    end else if (w_lastVec) begin
      r_pass <= (w_sigNext == golden);
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign pass = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_misr_sig_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_misr_sig_analyzer
// Purpose  : Directed self-checking bench: a legacy 4-bit instance and the
//            default 16-bit instance driven from one clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misr_sig_analyzer;

  logic        clock;
  logic        reset;

  // 4-bit legacy instance
  logic        start4;
  logic [3:0]  seed4;
  logic [15:0] num4;
  logic        valid4;
  logic [3:0]  data4;
  logic [3:0]  golden4;
  logic [3:0]  sig4;
  logic        busy4;
  logic        done4;
  logic        pass4;

  // 16-bit default instance
  logic        start16;
  logic [15:0] seed16;
  logic [15:0] num16;
  logic        valid16;
  logic [15:0] data16;
  logic [15:0] golden16;
  logic [15:0] sig16;
  logic        busy16;
  logic        done16;
  logic        pass16;

  int checks;
  int errors;

  misr_sig_analyzer #(
    .WIDTH   (4),
    .POLY    (bist_pkg::POLY4_LEGACY),
    .COUNT_W (16)
  ) dut4 (
    .clock        (clock),
    .reset        (reset),
    .start        (start4),
    .seed         (seed4),
    .num_patterns (num4),
    .data_valid   (valid4),
    .data_in      (data4),
    .golden       (golden4),
    .sig_out      (sig4),
    .busy         (busy4),
    .done         (done4),
    .pass         (pass4)
  );

  misr_sig_analyzer #(
    .WIDTH   (16),
    .POLY    (16'h100B),
    .COUNT_W (16)
  ) dut16 (
    .clock        (clock),
    .reset        (reset),
    .start        (start16),
    .seed         (seed16),
    .num_patterns (num16),
    .data_valid   (valid16),
    .data_in      (data16),
    .golden       (golden16),
    .sig_out      (sig16),
    .busy         (busy16),
    .done         (done16),
    .pass         (pass16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are stable and inputs may change afterwards
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin4(input logic [3:0] s, input logic [15:0] n, input logic [3:0] g);
    seed4   = s;
    num4    = n;
    golden4 = g;
    start4  = 1'b1;
    step();
    start4  = 1'b0;
  endtask

  task automatic test_reset();
    if ({sig4, busy4, done4, pass4} !== 7'b0) begin
      $display("FAIL reset4: got sig=%h busy=%b done=%b pass=%b, want all 0", sig4, busy4, done4, pass4);
      errors++;
    end
    checks++;
    if ({sig16, busy16, done16, pass16} !== 19'b0) begin
      $display("FAIL reset16: got sig=%h busy=%b done=%b pass=%b, want all 0", sig16, busy16, done16, pass16);
      errors++;
    end
    checks++;
  endtask

  // Seed 0, vectors 1,0,0,0,0 -> 1,2,4,8,3; run once per golden value
  task automatic test_basic(input logic [3:0] g, input logic expPass);
    logic [3:0] exp [5];
    exp[0] = 4'h1; exp[1] = 4'h2; exp[2] = 4'h4; exp[3] = 4'h8; exp[4] = 4'h3;
    begin4(4'h0, 16'd5, g);
    if (busy4 !== 1'b1 || done4 !== 1'b0 || sig4 !== 4'h0) begin
      $display("FAIL basic_start: got busy=%b done=%b sig=%h, want 1 0 0", busy4, done4, sig4);
      errors++;
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      valid4 = 1'b1;
      data4  = (i == 0) ? 4'h1 : 4'h0;
      step();
      if (sig4 !== exp[i]) begin
        $display("FAIL basic_sig[%0d]: got %h want %h", i, sig4, exp[i]);
        errors++;
      end
      checks++;
      if (done4 !== (i == 4)) begin
        $display("FAIL basic_done[%0d]: got %b want %b", i, done4, (i == 4));
        errors++;
      end
      checks++;
    end
    valid4 = 1'b0;
    if (pass4 !== expPass || busy4 !== 1'b0) begin
      $display("FAIL basic_pass: got pass=%b busy=%b want pass=%b busy=0", pass4, busy4, expPass);
      errors++;
    end
    checks++;
    // DONE freezes the signature and ignores later golden changes
    golden4 = ~g;
    valid4  = 1'b1;
    data4   = 4'hF;
    step();
    step();
    valid4  = 1'b0;
    if (sig4 !== 4'h3 || done4 !== 1'b1 || pass4 !== expPass) begin
      $display("FAIL basic_hold: got sig=%h done=%b pass=%b want 3 1 %b", sig4, done4, pass4, expPass);
      errors++;
    end
    checks++;
  endtask

  task automatic test_gaps();
    int badBusy;
    int earlyDone;
    badBusy   = 0;
    earlyDone = 0;
    begin4(4'h0, 16'd5, 4'h3);
    for (int i = 0; i < 5; i++) begin
      valid4 = 1'b0;
      for (int k = 0; k < (i % 4); k++) begin
        data4 = 4'hF;
        step();
        if (busy4 !== 1'b1) badBusy++;
        if (done4 !== 1'b0) earlyDone++;
      end
      valid4 = 1'b1;
      data4  = (i == 0) ? 4'h1 : 4'h0;
      step();
      if (i < 4 && busy4 !== 1'b1) badBusy++;
      if (i < 4 && done4 !== 1'b0) earlyDone++;
    end
    valid4 = 1'b0;
    if (badBusy != 0 || earlyDone != 0) begin
      $display("FAIL gaps_busy: got %0d busy drops and %0d early dones, want 0 0", badBusy, earlyDone);
      errors++;
    end
    checks++;
    if (sig4 !== 4'h3 || done4 !== 1'b1 || pass4 !== 1'b1) begin
      $display("FAIL gaps_final: got sig=%h done=%b pass=%b want 3 1 1", sig4, done4, pass4);
      errors++;
    end
    checks++;
  endtask

  task automatic test_zero_patterns();
    begin4(4'hA, 16'd0, 4'hA);
    if (done4 !== 1'b1 || pass4 !== 1'b1 || busy4 !== 1'b0 || sig4 !== 4'hA) begin
      $display("FAIL zero_count: got done=%b pass=%b busy=%b sig=%h want 1 1 0 a", done4, pass4, busy4, sig4);
      errors++;
    end
    checks++;
    begin4(4'hA, 16'd0, 4'hB);
    if (done4 !== 1'b1 || pass4 !== 1'b0) begin
      $display("FAIL zero_count_mismatch: got done=%b pass=%b want 1 0", done4, pass4);
      errors++;
    end
    checks++;
  endtask

  // Seed 5 with zero data: 5 -> a -> 7 -> e -> f -> d
  task automatic test_restart();
    logic [3:0] exp [5];
    exp[0] = 4'hA; exp[1] = 4'h7; exp[2] = 4'hE; exp[3] = 4'hF; exp[4] = 4'hD;
    begin4(4'h0, 16'd5, 4'h3);
    valid4 = 1'b1;
    data4  = 4'h1;
    step();
    data4  = 4'h0;
    step();
    // restart with a simultaneous vector that must be dropped
    seed4   = 4'h5;
    num4    = 16'd5;
    golden4 = 4'hD;
    start4  = 1'b1;
    data4   = 4'hF;
    step();
    start4  = 1'b0;
    if (sig4 !== 4'h5 || busy4 !== 1'b1 || done4 !== 1'b0) begin
      $display("FAIL restart_load: got sig=%h busy=%b done=%b want 5 1 0", sig4, busy4, done4);
      errors++;
    end
    checks++;
    data4 = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sig4 !== exp[i] || done4 !== (i == 4)) begin
        $display("FAIL restart_step[%0d]: got sig=%h done=%b want %h %b", i, sig4, done4, exp[i], (i == 4));
        errors++;
      end
      checks++;
    end
    valid4 = 1'b0;
    if (pass4 !== 1'b1) begin
      $display("FAIL restart_pass: got %b want 1", pass4);
      errors++;
    end
    checks++;
  endtask

  task automatic test_async_reset();
    begin4(4'h0, 16'd5, 4'h3);
    valid4 = 1'b1;
    data4  = 4'h1;
    step();
    data4  = 4'h0;
    step();
    #2;
    reset = 1'b1;
    #1;
    if ({sig4, busy4, done4, pass4} !== 7'b0) begin
      $display("FAIL async_reset: got sig=%h busy=%b done=%b pass=%b want all 0", sig4, busy4, done4, pass4);
      errors++;
    end
    checks++;
    step();
    #2;
    reset = 1'b0;
    data4 = 4'hF;
    step();
    step();
    step();
    valid4 = 1'b0;
    if (sig4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      $display("FAIL reset_idle_ignore: got sig=%h busy=%b done=%b want 0 0 0", sig4, busy4, done4);
      errors++;
    end
    checks++;
  endtask

  task automatic test_max_period();
    int early;
    early    = 0;
    seed16   = 16'h0001;
    num16    = 16'hFFFF;
    golden16 = 16'h0001;
    start16  = 1'b1;
    step();
    start16  = 1'b0;
    valid16  = 1'b1;
    data16   = 16'h0000;
    for (int i = 0; i < 65534; i++) begin
      step();
      if (sig16 === 16'h0001 || done16 !== 1'b0) early++;
    end
    if (early != 0) begin
      $display("FAIL period_early: got %0d early returns or dones, want 0", early);
      errors++;
    end
    checks++;
    step();
    valid16 = 1'b0;
    if (sig16 !== 16'h0001 || done16 !== 1'b1 || pass16 !== 1'b1 || busy16 !== 1'b0) begin
      $display("FAIL period_final: got sig=%h done=%b pass=%b busy=%b want 0001 1 1 0", sig16, done16, pass16, busy16);
      errors++;
    end
    checks++;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start4   = 1'b0; seed4  = '0; num4  = '0; valid4  = 1'b0; data4  = '0; golden4  = '0;
    start16  = 1'b0; seed16 = '0; num16 = '0; valid16 = 1'b0; data16 = '0; golden16 = '0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_basic(4'h3, 1'b1);
    test_basic(4'h4, 1'b0);
    test_gaps();
    test_zero_patterns();
    test_restart();
    test_async_reset();
    test_max_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
